// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with a line-burst AXI read refill,
// an uncached bypass path and cacop tag/valid maintenance operations.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rvalid,
  input  logic [31:0] pc,
  input  logic        uncache,
  input  logic        Is_flush,
  output logic        rready,
  output logic [63:0] rdata,
  output logic        flag_valid,
  output logic        data_valid,
  input  logic        cacop_en,
  input  logic [1:0]  cacop_code,
  input  logic [31:0] cacop_va,
  input  logic [31:0] cacop_pa,
  output logic        cacop_finish,
  output logic        i_arvalid,
  output logic [31:0] i_araddr,
  output logic [7:0]  i_arlen,
  input  logic        i_arready,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic        i_rlast,
  output logic        i_rready
);
  // state  | meaning
  // IDLE   | waiting for a fetch or cacop request
  // LOOKUP | tag compare on the array read issued at accept; hits answer here
  // MISS   | AR channel request outstanding
  // REFILL | collecting R beats into the return buffer
  // FILL   | writing the refilled line into the victim way
  // RESP   | answering from the return buffer
  // CACOP  | applying the maintenance op, pulsing cacop_finish
  localparam int SETS   = 1 << INDEX_W;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - INDEX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_WORDS * 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_FILL, S_RESP, S_CACOP
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_rd_q  [WAYS];
  logic [LINE_W-1:0] data_rd_q [WAYS];
  logic [SETS-1:0]   valid_q   [WAYS];
  logic [WAY_W-1:0]  rr_q      [SETS];
  logic [31:0]       rbuf_q    [LINE_WORDS];
  logic [WORD_W-1:0] beat_q;
  logic              init_q;

  logic [31:2]        req_addr_q;
  logic               req_unc_q, req_flush_q;
  logic [1:0]         cop_code_q;
  logic [INDEX_W-1:0] cop_va_idx_q, cop_pa_idx_q;
  logic [WAY_W-1:0]   cop_va_way_q;
  logic [TAG_W-1:0]   cop_pa_tag_q;

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], cacop_va[31:OFF_W+INDEX_W], cacop_va[OFF_W-1:WAY_W],
                         cacop_pa[OFF_W-1:0]};

  logic [INDEX_W-1:0] req_idx, cmp_idx, rd_idx;
  logic [TAG_W-1:0]   req_tag, cmp_tag;
  logic [WORD_W-1:0]  req_word;
  logic [LINE_W-1:0]  rbuf_line;
  logic [WAYS-1:0]    match;
  logic               hit, lookup_hit;
  logic [WAY_W-1:0]   hit_way, victim;
  logic               acc_cop, acc_fetch, accept;
  state_t             nxt_acc;
  logic               fill_we, cop_tag_we, cop_valid_clr;
  logic [WAY_W-1:0]   clr_way;
  logic [INDEX_W-1:0] clr_idx;

  assign req_idx  = req_addr_q[OFF_W +: INDEX_W];
  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_word = req_addr_q[2 +: WORD_W];
  assign cmp_idx  = (state_q == S_CACOP) ? cop_pa_idx_q : req_idx;
  assign cmp_tag  = (state_q == S_CACOP) ? cop_pa_tag_q : req_tag;
  assign rd_idx   = acc_cop ? cacop_pa[OFF_W +: INDEX_W] : pc[OFF_W +: INDEX_W];

  function automatic logic [63:0] pick(input logic [LINE_W-1:0] line,
                                       input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] w1;
    w1 = w + WORD_W'(1);
    return {line[{w1, 5'b0} +: 32], line[{w, 5'b0} +: 32]};
  endfunction

  always_comb begin
    rbuf_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) rbuf_line[i*32 +: 32] = rbuf_q[i];
  end

  // A hit needs exactly one matching valid way; duplicates are treated as a miss.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[w][cmp_idx] && (tag_rd_q[w] == cmp_tag);
      if (match[w]) hit_way = WAY_W'(w);
    end
    hit = (match != '0) && ((match & (match - {{(WAYS-1){1'b0}}, 1'b1})) == '0);
  end

  always_comb begin
    victim = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][req_idx]) victim = WAY_W'(w);
  end

  assign lookup_hit = (state_q == S_LOOKUP) && !req_unc_q && hit;

  always_comb begin
    case (state_q)
      S_IDLE:   rready = init_q;
      S_LOOKUP: rready = lookup_hit;
      S_RESP:   rready = 1'b1;
      default:  rready = 1'b0;
    endcase
  end

  assign acc_cop   = cacop_en && rready && (state_q == S_IDLE || state_q == S_LOOKUP);
  assign acc_fetch = rvalid && rready && !acc_cop;
  assign accept    = acc_cop || acc_fetch;
  assign nxt_acc   = acc_cop ? S_CACOP : (acc_fetch ? S_LOOKUP : S_IDLE);

  assign i_araddr = req_unc_q ? {req_addr_q[31:2], 2'b00}
                              : {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign i_arlen  = req_unc_q ? 8'd1 : 8'(LINE_WORDS - 1);

  always_comb begin
    state_d       = state_q;
    data_valid    = 1'b0;
    flag_valid    = 1'b0;
    rdata         = '0;
    i_arvalid     = 1'b0;
    i_rready      = 1'b0;
    cacop_finish  = 1'b0;
    fill_we       = 1'b0;
    cop_tag_we    = 1'b0;
    cop_valid_clr = 1'b0;
    clr_way       = cop_va_way_q;
    clr_idx       = cop_va_idx_q;
    case (state_q)
      S_IDLE: state_d = nxt_acc;
      S_LOOKUP: begin
        if (lookup_hit) begin
          data_valid = !Is_flush;
          rdata      = pick(data_rd_q[hit_way], req_word);
          flag_valid = (req_word != WORD_W'(LINE_WORDS - 1));
          state_d    = nxt_acc;
        end else if (Is_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        i_arvalid = 1'b1;
        if (i_arready) state_d = S_REFILL;
      end
      S_REFILL: begin
        i_rready = 1'b1;
        if (i_rvalid && i_rlast) state_d = req_unc_q ? S_RESP : S_FILL;
      end
      S_FILL: begin
        fill_we = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        data_valid = !req_flush_q && !Is_flush;
        rdata      = req_unc_q ? {rbuf_q[1], rbuf_q[0]} : pick(rbuf_line, req_word);
        flag_valid = req_unc_q || (req_word != WORD_W'(LINE_WORDS - 1));
        state_d    = nxt_acc;
      end
      S_CACOP: begin
        cacop_finish = 1'b1;
        state_d      = S_IDLE;
        case (cop_code_q)
          2'b00: cop_tag_we = 1'b1;
          2'b01: cop_valid_clr = 1'b1;
          2'b10: begin
            cop_valid_clr = hit;
            clr_way       = hit_way;
            clr_idx       = cop_pa_idx_q;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      init_q       <= 1'b0;
      req_addr_q   <= '0;
      req_unc_q    <= 1'b0;
      req_flush_q  <= 1'b0;
      cop_code_q   <= 2'b11;
      cop_va_idx_q <= '0;
      cop_va_way_q <= '0;
      cop_pa_idx_q <= '0;
      cop_pa_tag_q <= '0;
      beat_q       <= '0;
      for (int i = 0; i < LINE_WORDS; i++) rbuf_q[i] <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        req_addr_q   <= pc[31:2];
        req_unc_q    <= uncache && !acc_cop;
        req_flush_q  <= 1'b0;
        cop_code_q   <= acc_cop ? cacop_code : 2'b11;
        cop_va_idx_q <= cacop_va[OFF_W +: INDEX_W];
        cop_va_way_q <= cacop_va[WAY_W-1:0];
        cop_pa_idx_q <= cacop_pa[OFF_W +: INDEX_W];
        cop_pa_tag_q <= cacop_pa[31 -: TAG_W];
      end else if (Is_flush && (state_q == S_MISS || state_q == S_REFILL || state_q == S_FILL)) begin
        req_flush_q <= 1'b1;
      end
      if (i_rvalid && i_rready) begin
        rbuf_q[beat_q] <= i_rdata;
        beat_q         <= i_rlast ? '0 : beat_q + WORD_W'(1);
      end
      if (fill_we) begin
        valid_q[victim][req_idx] <= 1'b1;
        rr_q[req_idx]            <= rr_q[req_idx] + WAY_W'(1);
      end
      if (cop_valid_clr) valid_q[clr_way][clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd_q[w]  <= tag_mem[w][rd_idx];
        data_rd_q[w] <= data_mem[w][rd_idx];
      end
    end
    if (fill_we) begin
      tag_mem[victim][req_idx]  <= req_tag;
      data_mem[victim][req_idx] <= rbuf_line;
    end
    if (cop_tag_we) tag_mem[cop_va_way_q][cop_va_idx_q] <= '0;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (WAYS=2, INDEX_W=8, LINE_WORDS=4): a fetch
// vector table plus hand sequences for flush, cacop and reset mid-refill.
module tb_icache_nway;
  logic        clk, rstn;
  logic        rvalid, uncache, Is_flush, rready, flag_valid, data_valid;
  logic [31:0] pc;
  logic [63:0] rdata;
  logic        cacop_en, cacop_finish;
  logic [1:0]  cacop_code;
  logic [31:0] cacop_va, cacop_pa;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;

  icache_nway #(.WAYS(2), .INDEX_W(8), .LINE_WORDS(4)) dut (
    .clk(clk), .rstn(rstn), .rvalid(rvalid), .pc(pc), .uncache(uncache),
    .Is_flush(Is_flush), .rready(rready), .rdata(rdata), .flag_valid(flag_valid),
    .data_valid(data_valid), .cacop_en(cacop_en), .cacop_code(cacop_code),
    .cacop_va(cacop_va), .cacop_pa(cacop_pa), .cacop_finish(cacop_finish),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rready(i_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    bit          unc;
    bit          exp_miss;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    bit          exp_flag;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit unc, input int flush_beat,
                       output bit miss, output logic [31:0] ar_a, output logic [7:0] ar_l,
                       output bit dv, output logic [63:0] rd, output bit fv,
                       output int lat, output bit tmo);
    bit burst_done;
    miss = 0; dv = 0; fv = 0; rd = '0; ar_a = '0; ar_l = '0; lat = 0; tmo = 0;
    burst_done = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    if (!rready) begin tmo = 1; return; end
    rvalid = 1; pc = a; uncache = unc;
    @(posedge clk); #1;
    rvalid = 0; uncache = 0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (data_valid) begin dv = 1; rd = rdata; fv = flag_valid; lat = c; return; end
      if (burst_done && rready) begin lat = c; return; end
      if (i_arvalid && !miss) begin
        miss = 1; ar_a = i_araddr; ar_l = i_arlen;
        @(negedge clk);
        chk("ar_hold", {i_arvalid, i_araddr, i_arlen}, {1'b1, ar_a, ar_l});
        i_arready = 1;
        @(posedge clk); #1;
        i_arready = 0;
        for (int b = 0; b <= int'(ar_l); b++) begin
          @(negedge clk);
          i_rvalid = 1; i_rdata = memword(ar_a + 32'(4 * b));
          i_rlast = (b == int'(ar_l)); Is_flush = (b == flush_beat);
          @(posedge clk); #1;
          i_rvalid = 0; i_rlast = 0; Is_flush = 0;
        end
        burst_done = 1;
      end
    end
    tmo = 1;
  endtask

  task automatic cacop(input logic [1:0] code, input logic [31:0] va, input logic [31:0] pa,
                       output int lat, output bit extra);
    lat = 0; extra = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    cacop_en = 1; cacop_code = code; cacop_va = va; cacop_pa = pa;
    @(posedge clk); #1;
    cacop_en = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (cacop_finish) begin lat = c; break; end
    end
    @(negedge clk);
    extra = cacop_finish;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_outs"}, {data_valid, i_arvalid, i_rready, cacop_finish}, 4'b0000);
    chk({tag, "_rdata"}, rdata, 64'h0);
  endtask

  // Fetch that is expected to miss (or hit) with no extra checking of data.
  task automatic probe(input string name, input logic [31:0] a, input bit exp_miss);
    bit miss, dv, fv, tmo; logic [31:0] aa; logic [7:0] al; logic [63:0] rd; int lat;
    fetch(a, 1'b0, -1, miss, aa, al, dv, rd, fv, lat, tmo);
    chk({name, "_tmo"}, tmo, 0);
    chk({name, "_miss"}, miss, exp_miss);
    chk({name, "_dv"}, dv, 1);
    chk({name, "_lo"}, rd[31:0], memword(a & ~32'h3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit miss, dv, fv, tmo, extra;
    logic [31:0] aa, base;
    logic [7:0]  al;
    logic [63:0] rd;
    int lat;

    vecs[0]  = '{32'h1C00_0000, 1'b0, 1'b1, 32'h1C00_0000, 8'd3, 1'b1};
    vecs[1]  = '{32'h1C00_0000, 1'b0, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[2]  = '{32'h1C00_0004, 1'b0, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[3]  = '{32'h1C00_000C, 1'b0, 1'b0, 32'h0,         8'd0, 1'b0};
    vecs[4]  = '{32'h1C00_100C, 1'b0, 1'b1, 32'h1C00_1000, 8'd3, 1'b0};
    vecs[5]  = '{32'h1C00_2000, 1'b0, 1'b1, 32'h1C00_2000, 8'd3, 1'b1};
    vecs[6]  = '{32'h1C00_1000, 1'b0, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[7]  = '{32'h1C00_0000, 1'b0, 1'b1, 32'h1C00_0000, 8'd3, 1'b1};
    vecs[8]  = '{32'h1C00_1008, 1'b0, 1'b1, 32'h1C00_1000, 8'd3, 1'b1};
    vecs[9]  = '{32'h1C00_0008, 1'b0, 1'b0, 32'h0,         8'd0, 1'b1};
    vecs[10] = '{32'hBFAF_8000, 1'b1, 1'b1, 32'hBFAF_8000, 8'd1, 1'b1};
    vecs[11] = '{32'hBFAF_8000, 1'b0, 1'b1, 32'hBFAF_8000, 8'd3, 1'b1};
    vecs[12] = '{32'h1C00_1004, 1'b1, 1'b1, 32'h1C00_1004, 8'd1, 1'b1};
    vecs[13] = '{32'h1C00_0034, 1'b0, 1'b1, 32'h1C00_0030, 8'd3, 1'b1};
    vecs[14] = '{32'h1C00_1004, 1'b0, 1'b0, 32'h0,         8'd0, 1'b1};

    rstn = 0; rvalid = 0; pc = '0; uncache = 0; Is_flush = 0;
    cacop_en = 0; cacop_code = 2'b11; cacop_va = '0; cacop_pa = '0;
    i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rlast = 0;
    #2;
    chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("idle_rready", rready, 1);

    for (int v = 0; v < 15; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      fetch(vecs[v].pc, vecs[v].unc, -1, miss, aa, al, dv, rd, fv, lat, tmo);
      base = vecs[v].pc & ~32'h3;
      chk({nm, "_tmo"}, tmo, 0);
      chk({nm, "_miss"}, miss, vecs[v].exp_miss);
      if (vecs[v].exp_miss) begin
        chk({nm, "_araddr"}, aa, vecs[v].exp_addr);
        chk({nm, "_arlen"}, al, vecs[v].exp_len);
      end else begin
        chk({nm, "_latency"}, lat, 1);
      end
      chk({nm, "_dv"}, dv, 1);
      chk({nm, "_flag"}, fv, vecs[v].exp_flag);
      chk({nm, "_lo"}, rd[31:0], memword(base));
      if (vecs[v].exp_flag) chk({nm, "_hi"}, rd[63:32], memword(base + 32'h4));
    end

    // Flush during refill: burst drains, no data, line still installed.
    fetch(32'h1C00_0050, 1'b0, 1, miss, aa, al, dv, rd, fv, lat, tmo);
    chk("flush_tmo", tmo, 0);
    chk("flush_miss", miss, 1);
    chk("flush_dv", dv, 0);
    probe("flush_refetch", 32'h1C00_0050, 1'b0);

    // cacop 10: invalidate by physical address.
    cacop(2'b10, 32'h0, 32'h1C00_0050, lat, extra);
    chk("cop10_lat", lat, 1);
    chk("cop10_pulse", extra, 0);
    probe("cop10_refetch", 32'h1C00_0050, 1'b1);

    // cacop 11: no effect.
    cacop(2'b11, 32'h0000_0050, 32'h1C00_0050, lat, extra);
    chk("cop11_lat", lat, 1);
    probe("cop11_refetch", 32'h1C00_0050, 1'b0);

    // cacop 01: clear valid of set 3 way 0.
    cacop(2'b01, 32'h0000_0030, 32'h0, lat, extra);
    chk("cop01_lat", lat, 1);
    probe("cop01_refetch", 32'h1C00_0034, 1'b1);

    // cacop 00: clear tag of set 5 way 0.
    cacop(2'b00, 32'h0000_0050, 32'h0, lat, extra);
    chk("cop00_lat", lat, 1);
    probe("cop00_refetch", 32'h1C00_0050, 1'b1);

    // Reset in the middle of a refill burst.
    @(negedge clk);
    rvalid = 1; pc = 32'h1C00_0070; uncache = 0;
    @(posedge clk); #1;
    rvalid = 0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!i_arvalid && n < 10) begin @(negedge clk); n++; end
      chk("rst_arvalid_seen", i_arvalid, 1);
    end
    i_arready = 1;
    @(posedge clk); #1;
    i_arready = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      i_rvalid = 1; i_rdata = memword(32'h1C00_0070 + 32'(4 * b)); i_rlast = 0;
      @(posedge clk); #1;
      i_rvalid = 0;
    end
    chk("rst_in_refill", i_rready, 1);
    #2;
    rstn = 0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rstn = 1;
    probe("rst_refetch_b", 32'h1C00_1004, 1'b1);
    probe("rst_refetch_a", 32'h1C00_0070, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
